uart_tx_fifo: RTL and testbench
===============================

# uart_tx_fifo

Byte buffer and launch controller that sits directly upstream of the UART transmitter. Host logic pushes bytes at core clock rate; the block stores them in a circular FIFO and hands them one at a time to the transmitter by pulsing its start input and following its busy output. It absorbs bursts so the host never has to track baud timing.

## Interface
- DEPTH, 16, FIFO entries; power of two, ≥2
- ACK_TIMEOUT, 16, cycles to wait for tx_busy to rise after a start pulse; ≥2
- clk  in  1  core clock
- rst_n  in  1  asynchronous, active-low reset
- wr_en  in  1  push wr_data this cycle
- wr_data  in  8  byte to queue
- flush  in  1  synchronous FIFO clear
- tx_busy  in  1  transmitter frame in flight
- tx_start  out  1  one-cycle start pulse to transmitter
- tx_data  out  8  byte presented to transmitter
- full  out  1  level == DEPTH
- empty  out  1  level == 0
- level  out  $clog2(DEPTH)+1  entries stored
- overflow  out  1  sticky: push attempted while full
- timeout_err  out  1  one-cycle pulse: transmitter never acknowledged start

## Operation
- Reset, asynchronous on rst_n low: pointers 0, level 0, empty 1, full 0, overflow 0, timeout_err 0, tx_start 0, tx_data 8'h00, FSM IDLE, timeout counter 0.
- Storage: wr_ptr/rd_ptr of $clog2(DEPTH) bits, wrapping naturally at DEPTH; level tracks occupancy separately. full/empty are derived from level.
- Push: wr_en && !full stores wr_data at wr_ptr, wr_ptr+1. wr_en && full: data discarded, overflow set to 1.
- Pop: performed only by the FSM in IDLE.
- Simultaneous push and pop: both take effect, level unchanged. When full at the start of the cycle, the push is rejected even if a pop occurs the same cycle; overflow is set.
- flush: pointers and level go to 0 and overflow clears. It overrides any push and pop in the same cycle; a push in that cycle is dropped and does not set overflow. flush does not affect FSM, tx_data or an in-flight frame.
- FSM states:
  - IDLE: if !empty && !tx_busy && !flush, then tx_data <= mem[rd_ptr], rd_ptr+1, level-1, go to START.
  - START: tx_start=1 for exactly this cycle; clear the timeout counter; go to WAIT_HI.
  - WAIT_HI:
    - If tx_busy: go to WAIT_LO.
    - Otherwise increment the counter.
    - When the counter reaches ACK_TIMEOUT-1: pulse timeout_err, go to IDLE. The byte is lost and is not re-queued.
  - WAIT_LO: when tx_busy is 0, go to IDLE.
- tx_data holds stable from the pop until the next pop.
- tx_start is asserted only in START and never on two consecutive cycles.

## Timing
- Push at cycle N: level/empty update at N+1.
- Empty FIFO, transmitter idle, push at N:
  - pop at N+1
  - tx_start high at N+2, with tx_data valid at N+2
- Back-to-back bytes: next pop occurs the first IDLE cycle after tx_busy falls, so there are ≥2 cycles between the tx_busy fall and the next tx_start.
- tx_busy high while in IDLE (e.g. externally started frame): no pop until it is low.
- Reset mid-frame: FSM returns to IDLE immediately and buffered bytes are lost. tx_start is never glitched high during or on exit from reset.
- All outputs are registered except full, empty and level, which are combinational from the level register.

## Structure
- Shared package uart_pkg:
  - FSM state typedef (IDLE=0, START=1, WAIT_HI=2, WAIT_LO=3)
  - default DEPTH and ACK_TIMEOUT constants
  - byte width constant 8
- Sub-module uart_fifo_mem: DEPTH×8 storage with pointers, level, full/empty, flush and overflow.
- uart_tx_fifo instantiates uart_fifo_mem and adds the launch FSM and timeout counter.
- Integration: tx_start→transmitter go, tx_data→transmitter data input, transmitter busy→tx_busy.

## Test plan
- Reset with rst_n low mid-stream: all outputs at reset values within the same cycle, asynchronously. After release, push 8'hA5 with a transmitter model that raises busy 1 cycle after start and holds it 20 cycles: tx_start 2 cycles after the push with tx_data=8'hA5, and exactly one pulse.
- Burst 8'h01..8'h10 (16 bytes, DEPTH=16) while the model is busy: full=1, level=16. A 17th push (8'hFF) sets overflow and is never transmitted. The bytes emerge in order 01..10, each start only after busy falls.
- Push and pop in the same cycle at level 3: level stays 3. Push at level 16 with a coincident pop: rejected, overflow=1.
- flush asserted together with a push of 8'h33 at level 5: level=0, empty=1, overflow cleared, 8'h33 never sent. A byte already in flight completes unaffected.
- Model never raises busy: timeout_err pulses exactly once, ACK_TIMEOUT cycles after WAIT_HI is entered. The FSM returns to IDLE and sends the next queued byte (8'h5A) normally.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared types and defaults for the UART transmit buffer and its launch controller.
package uart_pkg;

  localparam int UART_DEPTH       = 16;
  localparam int UART_ACK_TIMEOUT = 16;
  localparam int BYTE_W           = 8;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_START   = 2'd1,
    ST_WAIT_HI = 2'd2,
    ST_WAIT_LO = 2'd3
  } tx_state_e;

endpackage

// File: rtl/uart_fifo_mem.sv
// Circular byte FIFO: push/pop take effect on the clock edge; read data is mem[rd_ptr] combinationally.
// A push while full is dropped and sets the sticky overflow; flush clears everything and wins over push/pop.
module uart_fifo_mem
  import uart_pkg::*;
#(
  parameter int DEPTH = UART_DEPTH
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    push_i,
  input  logic [BYTE_W-1:0]       push_dat_i,
  input  logic                    pop_i,
  input  logic                    flush_i,
  output logic [BYTE_W-1:0]       rd_dat_o,
  output logic                    full_o,
  output logic                    empty_o,
  output logic [$clog2(DEPTH):0]  level_o,
  output logic                    overflow_o
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int LVL_W = PTR_W + 1;

  logic [BYTE_W-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [LVL_W-1:0]  level_q, level_d;
  logic              overflow_q, overflow_d;
  logic              push_ok, pop_ok;

  assign full_o     = (level_q == LVL_W'(DEPTH));
  assign empty_o    = (level_q == '0);
  assign level_o    = level_q;
  assign overflow_o = overflow_q;
  assign rd_dat_o   = mem_q[rd_ptr_q];

  // Fullness is judged at the start of the cycle, so a coincident pop never makes room.
  assign push_ok = push_i && !full_o && !flush_i;
  assign pop_ok  = pop_i && !empty_o && !flush_i;

  always_comb begin
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    level_d    = level_q;
    overflow_d = overflow_q;
    if (flush_i) begin
      wr_ptr_d   = '0;
      rd_ptr_d   = '0;
      level_d    = '0;
      overflow_d = 1'b0;
    end else begin
      if (push_ok) wr_ptr_d = wr_ptr_q + 1'b1;
      if (pop_ok)  rd_ptr_d = rd_ptr_q + 1'b1;
      if (push_ok && !pop_ok)      level_d = level_q + 1'b1;
      else if (!push_ok && pop_ok) level_d = level_q - 1'b1;
      if (push_i && full_o) overflow_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      level_q    <= '0;
      overflow_q <= 1'b0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      level_q    <= level_d;
      overflow_q <= overflow_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wr_ptr_q] <= push_dat_i;
  end

endmodule

// File: rtl/uart_tx_fifo.sv
// Buffers host bytes and launches them one at a time into the UART transmitter (start pulse 2 cycles after a push into an idle path).
// Host sees full/overflow only; a new byte is launched only once the transmitter is idle, and an unacknowledged start is dropped with timeout_err.
module uart_tx_fifo
  import uart_pkg::*;
#(
  parameter int DEPTH       = UART_DEPTH,
  parameter int ACK_TIMEOUT = UART_ACK_TIMEOUT
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    wr_en,
  input  logic [BYTE_W-1:0]       wr_data,
  input  logic                    flush,
  input  logic                    tx_busy,
  output logic                    tx_start,
  output logic [BYTE_W-1:0]       tx_data,
  output logic                    full,
  output logic                    empty,
  output logic [$clog2(DEPTH):0]  level,
  output logic                    overflow,
  output logic                    timeout_err
);

  localparam int CNT_W = $clog2(ACK_TIMEOUT);

  tx_state_e         state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [BYTE_W-1:0] tx_data_q;
  logic              tx_start_q;
  logic              timeout_q, timeout_d;
  logic              pop;
  logic [BYTE_W-1:0] fifo_rd_dat;

  uart_fifo_mem #(.DEPTH(DEPTH)) u_fifo (
    .clk        (clk),
    .rst_n      (rst_n),
    .push_i     (wr_en),
    .push_dat_i (wr_data),
    .pop_i      (pop),
    .flush_i    (flush),
    .rd_dat_o   (fifo_rd_dat),
    .full_o     (full),
    .empty_o    (empty),
    .level_o    (level),
    .overflow_o (overflow)
  );

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    pop       = 1'b0;
    timeout_d = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (!empty && !tx_busy && !flush) begin
          pop     = 1'b1;
          state_d = ST_START;
        end
      end
      ST_START: begin
        cnt_d   = '0;
        state_d = ST_WAIT_HI;
      end
      ST_WAIT_HI: begin
        if (tx_busy) begin
          state_d = ST_WAIT_LO;
        end else if (cnt_q == CNT_W'(ACK_TIMEOUT - 1)) begin
          timeout_d = 1'b1;
          state_d   = ST_IDLE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      ST_WAIT_LO: begin
        if (!tx_busy) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // tx_start is registered from the next state so it is high exactly while in START.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      cnt_q      <= '0;
      tx_data_q  <= '0;
      tx_start_q <= 1'b0;
      timeout_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      tx_start_q <= (state_d == ST_START);
      timeout_q  <= timeout_d;
      if (pop) tx_data_q <= fifo_rd_dat;
    end
  end

  assign tx_start    = tx_start_q;
  assign tx_data     = tx_data_q;
  assign timeout_err = timeout_q;

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Scoreboard bench for uart_tx_fifo with a behavioural transmitter that acknowledges starts.
module tb_uart_tx_fifo;

  localparam int DEPTH    = 16;
  localparam int AT       = 16;
  localparam int BUSY_LEN = 20;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       wr_en;
  logic [7:0] wr_data;
  logic       flush;
  logic       tx_busy;
  logic       tx_start;
  logic [7:0] tx_data;
  logic       full;
  logic       empty;
  logic [4:0] level;
  logic       overflow;
  logic       timeout_err;

  int         vec_cnt = 0;
  int         err_cnt = 0;
  int         start_cnt = 0;
  bit         ack_en = 1'b1;
  bit         prev_start = 1'b0;
  logic [7:0] exp_q [$];

  uart_tx_fifo #(.DEPTH(DEPTH), .ACK_TIMEOUT(AT)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .wr_en       (wr_en),
    .wr_data     (wr_data),
    .flush       (flush),
    .tx_busy     (tx_busy),
    .tx_start    (tx_start),
    .tx_data     (tx_data),
    .full        (full),
    .empty       (empty),
    .level       (level),
    .overflow    (overflow),
    .timeout_err (timeout_err)
  );

  always #5 clk = ~clk;

  // Transmitter: busy rises the cycle after an acknowledged start and stays high BUSY_LEN cycles.
  initial begin
    tx_busy = 1'b0;
    forever begin
      @(negedge clk);
      if (tx_start && ack_en) begin
        @(posedge clk); #1 tx_busy = 1'b1;
        repeat (BUSY_LEN) @(posedge clk);
        #1 tx_busy = 1'b0;
      end
    end
  end

  // Scoreboard: every start must carry the oldest expected byte, never back-to-back, never while busy.
  always @(negedge clk) begin
    if (rst_n && tx_start) begin
      start_cnt++;
      vec_cnt++;
      if (prev_start) begin err_cnt++; $display("FAIL start_consecutive: tx_start high two cycles running"); end
      vec_cnt++;
      if (tx_busy !== 1'b0) begin err_cnt++; $display("FAIL start_while_busy: tx_busy=%b required 0", tx_busy); end
      vec_cnt++;
      if (exp_q.size() == 0) begin
        err_cnt++; $display("FAIL unexpected_start: tx_data=%02h with no byte expected", tx_data);
      end else begin
        logic [7:0] e;
        e = exp_q.pop_front();
        if (tx_data !== e) begin err_cnt++; $display("FAIL tx_data_order: got %02h required %02h", tx_data, e); end
      end
    end
    prev_start = rst_n && tx_start;
  end

  task automatic step();
    @(posedge clk); #2;
  endtask

  task automatic push_byte(input logic [7:0] b, input bit accept);
    wr_en = 1'b1; wr_data = b;
    if (accept) exp_q.push_back(b);
    step();
    wr_en = 1'b0;
  endtask

  task automatic wait_busy(input logic val, input int budget);
    int n;
    n = 0;
    while (tx_busy !== val && n < budget) begin step(); n++; end
    vec_cnt++;
    if (tx_busy !== val) begin err_cnt++; $display("FAIL wait_busy: tx_busy=%b required %b within %0d cycles", tx_busy, val, budget); end
  endtask

  task automatic wait_drain(input int budget);
    int n;
    n = 0;
    while (!(exp_q.size() == 0 && empty === 1'b1 && tx_busy === 1'b0) && n < budget) begin step(); n++; end
    repeat (3) step();
    vec_cnt++;
    if (exp_q.size() != 0) begin err_cnt++; $display("FAIL drain: %0d bytes never sent, required 0", exp_q.size()); end
  endtask

  task automatic check_reset_vals(input string tag);
    vec_cnt++;
    if ({tx_start, tx_data, full, empty, level, overflow, timeout_err} !== {1'b0, 8'h00, 1'b0, 1'b1, 5'd0, 1'b0, 1'b0}) begin
      err_cnt++;
      $display("FAIL %s: start=%b data=%02h full=%b empty=%b level=%0d ovf=%b to=%b required 0/00/0/1/0/0/0",
               tag, tx_start, tx_data, full, empty, level, overflow, timeout_err);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b1; wr_en = 1'b0; wr_data = 8'h00; flush = 1'b0;
    #1 rst_n = 1'b0;
    #1 check_reset_vals("reset_initial");
    #10 rst_n = 1'b1;
    step();
    push_byte(8'h11, 1'b1);
    push_byte(8'h22, 1'b1);
    wait_busy(1'b1, 20);
    step(); step();
    #1 rst_n = 1'b0;
    exp_q.delete();
    #1 check_reset_vals("reset_midstream");
    #10 rst_n = 1'b1;
    wait_busy(1'b0, 40);
    step(); step();
    vec_cnt++;
    if (start_cnt != 1) begin err_cnt++; $display("FAIL reset_no_restart: starts=%0d required 1", start_cnt); end
  endtask

  task automatic test_first_byte();
    int s0;
    s0 = start_cnt;
    push_byte(8'hA5, 1'b1);
    vec_cnt++;
    if (level !== 5'd1 || empty !== 1'b0 || tx_start !== 1'b0) begin
      err_cnt++; $display("FAIL first_push_n1: level=%0d empty=%b start=%b required 1/0/0", level, empty, tx_start);
    end
    step();
    vec_cnt++;
    if (tx_start !== 1'b1 || tx_data !== 8'hA5) begin
      err_cnt++; $display("FAIL first_start_n2: start=%b data=%02h required 1/a5", tx_start, tx_data);
    end
    repeat (30) step();
    vec_cnt++;
    if (start_cnt - s0 != 1) begin err_cnt++; $display("FAIL first_one_pulse: pulses=%0d required 1", start_cnt - s0); end
    wait_drain(100);
  endtask

  task automatic test_burst();
    push_byte(8'hC3, 1'b1);
    wait_busy(1'b1, 20);
    for (int i = 1; i <= 16; i++) push_byte(8'(i), 1'b1);
    vec_cnt++;
    if (full !== 1'b1 || level !== 5'd16 || empty !== 1'b0 || overflow !== 1'b0) begin
      err_cnt++; $display("FAIL burst_full: full=%b level=%0d empty=%b ovf=%b required 1/16/0/0", full, level, empty, overflow);
    end
    push_byte(8'hFF, 1'b0);
    vec_cnt++;
    if (overflow !== 1'b1 || level !== 5'd16) begin
      err_cnt++; $display("FAIL burst_overflow: ovf=%b level=%0d required 1/16", overflow, level);
    end
    wait_drain(1500);
  endtask

  task automatic test_flush();
    int s0;
    push_byte(8'hF0, 1'b1);
    wait_busy(1'b1, 20);
    s0 = start_cnt;
    for (int i = 0; i < 5; i++) push_byte(8'h41 + 8'(i), 1'b1);
    vec_cnt++;
    if (level !== 5'd5) begin err_cnt++; $display("FAIL flush_pre_level: level=%0d required 5", level); end
    wr_en = 1'b1; wr_data = 8'h33; flush = 1'b1;
    exp_q.delete();
    step();
    wr_en = 1'b0; flush = 1'b0;
    vec_cnt++;
    if (level !== 5'd0 || empty !== 1'b1 || overflow !== 1'b0 || tx_data !== 8'hF0) begin
      err_cnt++; $display("FAIL flush_clear: level=%0d empty=%b ovf=%b data=%02h required 0/1/0/f0", level, empty, overflow, tx_data);
    end
    wait_drain(100);
    vec_cnt++;
    if (start_cnt != s0) begin err_cnt++; $display("FAIL flush_no_send: extra starts=%0d required 0", start_cnt - s0); end
  endtask

  task automatic test_push_pop_same_cycle();
    push_byte(8'h60, 1'b1);
    wait_busy(1'b1, 20);
    push_byte(8'h61, 1'b1);
    push_byte(8'h62, 1'b1);
    push_byte(8'h63, 1'b1);
    wait_busy(1'b0, 40);
    step();
    push_byte(8'h64, 1'b1);
    vec_cnt++;
    if (level !== 5'd3 || tx_start !== 1'b1) begin
      err_cnt++; $display("FAIL pushpop_level3: level=%0d start=%b required 3/1", level, tx_start);
    end
    for (int i = 0; i < 13; i++) push_byte(8'h65 + 8'(i), 1'b1);
    vec_cnt++;
    if (level !== 5'd16 || full !== 1'b1 || overflow !== 1'b0) begin
      err_cnt++; $display("FAIL pushpop_fill: level=%0d full=%b ovf=%b required 16/1/0", level, full, overflow);
    end
    wait_busy(1'b1, 20);
    wait_busy(1'b0, 40);
    step();
    push_byte(8'hEE, 1'b0);
    vec_cnt++;
    if (level !== 5'd15 || overflow !== 1'b1 || tx_start !== 1'b1) begin
      err_cnt++; $display("FAIL pushpop_full_reject: level=%0d ovf=%b start=%b required 15/1/1", level, overflow, tx_start);
    end
    wait_drain(1500);
  endtask

  task automatic test_timeout();
    int n;
    int pulses;
    ack_en = 1'b0;
    push_byte(8'h77, 1'b1);
    push_byte(8'h5A, 1'b1);
    n = 0;
    while (tx_start !== 1'b1 && n < 20) begin step(); n++; end
    vec_cnt++;
    if (tx_start !== 1'b1) begin err_cnt++; $display("FAIL timeout_start: no start within 20 cycles"); end
    pulses = 0;
    for (int k = 1; k <= AT + 2; k++) begin
      step();
      if (k == 1) ack_en = 1'b1;
      if (timeout_err === 1'b1) pulses++;
      if (k == AT + 1) begin
        vec_cnt++;
        if (timeout_err !== 1'b1) begin err_cnt++; $display("FAIL timeout_when: timeout_err=%b required 1 at +%0d", timeout_err, AT); end
      end
    end
    vec_cnt++;
    if (pulses != 1) begin err_cnt++; $display("FAIL timeout_pulses: pulses=%0d required 1", pulses); end
    vec_cnt++;
    if (tx_start !== 1'b1 || tx_data !== 8'h5A) begin
      err_cnt++; $display("FAIL timeout_next: start=%b data=%02h required 1/5a", tx_start, tx_data);
    end
    wait_drain(100);
  endtask

  initial begin
    test_reset();
    test_first_byte();
    test_burst();
    test_flush();
    test_push_pop_same_cycle();
    test_timeout();
    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1);
  end

endmodule
